// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter (8N1 / 8N2) with an internal baud divider.
// Rev 1.0 - initial release.
`default_nettype none

module uart_tx_fifo #(
   parameter int N    = 8,
   parameter int STOP = 0,
   parameter int DIV  = 434,
   parameter int AW   = 4
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          wr_en,
   input  logic [N-1:0]  data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          ovf,
   output logic          q,
   output logic          busy
);
   localparam int            DEPTH       = 2**AW;
   localparam int            IW          = $clog2(N) + 1;
   localparam logic [15:0]   C_DIV_M1    = 16'(DIV - 1);
   localparam logic [IW-1:0] C_LAST_BIT  = IW'(N - 1);
   localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP);
   localparam logic [AW:0]   C_FULL_XOR  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP_B} state_t;

   state_t        r_state;
   logic [N-1:0]  r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [15:0]   r_cnt;
   logic [N-1:0]  r_shift;
   logic [IW-1:0] r_idx;

   logic          w_push;
   logic          w_pop;
   logic          w_tick;
   logic          w_frame_end;
   logic [AW:0]   w_wptr_nxt;
   logic [AW:0]   w_rptr_nxt;
   logic [N-1:0]  w_shift_nxt;
   logic [N-1:0]  w_head;

   assign w_tick      = (r_cnt == C_DIV_M1);
   assign w_frame_end = (r_state == S_STOP_B) && w_tick && (r_idx == C_LAST_STOP);
   assign w_pop       = !empty && ((r_state == S_IDLE) || w_frame_end);
   // full is the registered pre-edge flag, so a write while full is dropped even if a pop happens now
   assign w_push      = wr_en && !full;
   assign w_wptr_nxt  = r_wptr + (AW+1)'(w_push);
   assign w_rptr_nxt  = r_rptr + (AW+1)'(w_pop);
   assign w_shift_nxt = r_shift >> 1;
   assign w_head      = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= data;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         r_wptr <= w_wptr_nxt;
         r_rptr <= w_rptr_nxt;
         level  <= w_wptr_nxt - w_rptr_nxt;
         full   <= (w_wptr_nxt ^ w_rptr_nxt) == C_FULL_XOR;
         empty  <= (w_wptr_nxt == w_rptr_nxt);
         ovf    <= wr_en && full;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         q       <= 1'b1;
         busy    <= 1'b0;
      end else begin
         if (r_state != S_IDLE) begin
            r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_idx   <= '0;
                  r_cnt   <= '0;
                  q       <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  q       <= r_shift[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_idx == C_LAST_BIT) begin
                     q       <= 1'b1;
                     r_idx   <= '0;
                     r_state <= S_STOP_B;
                  end else begin
                     r_shift <= w_shift_nxt;
                     r_idx   <= r_idx + 1'b1;
                     q       <= w_shift_nxt[0];
                  end
               end
            end
            S_STOP_B: begin
               // r_idx counts stop bits here; a queued byte starts on the same edge
               if (w_tick) begin
                  if (r_idx != C_LAST_STOP) begin
                     r_idx <= r_idx + 1'b1;
                  end else if (w_pop) begin
                     r_shift <= w_head;
                     r_idx   <= '0;
                     q       <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     busy    <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter, the transmit-side counterpart to the team's UART receiver, running on the system clock (clk50m domain).
- Accepts bytes through a simple write port into an internal FIFO.
- Generates its own baud timing from the system clock.
- Serialises frames 8N1, or 8N2 when STOP=1.
- Lets a producer queue bursts without a separate tx_clk or per-byte start/ready handshaking.

Parameters:
N, 8, data bits per frame; sent LSB first.
STOP, 0, stop bits: 0 gives one stop bit, 1 gives two.
DIV, 434, system clocks per bit (50 MHz / 115200); legal range 2..65535.
AW, 4, FIFO address width; depth = 2**AW entries.

Ports:
clk  in  1  system clock; all logic on rising edge.
nrst  in  1  asynchronous active-low reset.
wr_en  in  1  write strobe; one entry per cycle when high.
data  in  N  write data, sampled on clk rise when wr_en=1.
full  out  1  FIFO holds 2**AW entries.
empty  out  1  FIFO holds 0 entries.
level  out  AW+1  current FIFO occupancy, 0..2**AW.
ovf  out  1  one-cycle pulse: a write arrived while full and was dropped.
q  out  1  serial line; idles high.
busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (nrst=0, asynchronous)
  - q=1, busy=0, ovf=0, empty=1, full=0, level=0.
  - FIFO pointers cleared and baud counter cleared.
  - A frame in progress is aborted immediately; no partial bits are resumed after release.
- FIFO
  - Registered, non-fall-through; pointers wrap modulo 2**AW, with an extra pointer bit distinguishing full from empty.
  - A write while full is dropped, ovf pulses for 1 cycle and contents are unchanged. full is evaluated before any same-cycle pop, so the write is dropped even if a pop occurs.
  - A write and a pop in the same cycle leave level unchanged.
  - full, empty and level are registered and reflect the state after each edge.
- Baud counter
  - Counts 0..DIV-1 only while busy and wraps at DIV-1; the wrap is the bit boundary.
  - Cleared to 0 on each IDLE→START transition.
  - Every bit lasts exactly DIV clocks.
- FSM states: IDLE, START, DATA, STOP_B.
  - IDLE: q=1. If empty=0, pop the head entry into the shift register, set bit index 0 and go to START.
  - START: q=0 for DIV clocks, then DATA.
  - DATA: q=shift[0]; at each bit boundary shift right and increment the index. After bit N-1 go to STOP_B.
  - STOP_B: q=1 for (1+STOP)*DIV clocks. At the end, if FIFO is non-empty, pop and go directly to START on the same edge (zero idle gap); otherwise go to IDLE.
- Latency
  - A write at edge k into an empty, idle block pops at edge k+1; q falls at edge k+1.
  - Frame length is (2+N+STOP)*DIV clocks. Back-to-back frames are contiguous.
- Arithmetic: the baud counter is 16 bits wide and the bit index is clog2(N)+1 bits.
- q is driven directly from a flop; no combinational glitches.
- Writes during a frame never disturb the frame in flight.

Test Plan:
- Single byte, DIV=4, N=8, STOP=0: write 8'h5A into an idle block.
  - q low 4 clocks.
  - Then bits 0,1,0,1,1,0,1,0, each 4 clocks.
  - Then high 4 clocks.
  - busy high for exactly 40 clocks.
  - q falls 1 clock after the write edge.
- Burst of 8'h00, 8'hFF, 8'h2B on consecutive cycles:
  - level reaches 2 (the first byte has already popped).
  - Three contiguous 40-clock frames with no idle cycle between them.
  - Receiver loopback (UART_RX with matching DIV) returns 00, FF, 2B in order.
- STOP=1 with 8'h81: stop level lasts 8 clocks and the frame totals 44 clocks.
- Overflow with AW=2 while a frame is active:
  - Write 5 bytes back-to-back: the first pops, the next 4 fill the FIFO, full=1.
  - A 6th write pulses ovf for 1 cycle, level stays 4, and the dropped byte never appears on q.
- Reset mid-frame: drop nrst during DATA bit 3.
  - q=1 asynchronously; empty=1, level=0, busy=0.
  - After release with no writes, q stays high for 200 clocks.
- Wrap-around: with AW=2, push 12 bytes 8'h04..8'h0F while draining.
  - All 12 are transmitted in order and level never exceeds 4.
